apb_req_arbiter: RTL

//  Shares one APB_Master between NREQ requesters (e.g. AHB2APB bridge, DMA, debug port).

---
 rtl/apb_arb_pkg.sv | 25 ++
 rtl/apb_rr_pick.sv | 43 ++++
 rtl/apb_req_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared definitions for the APB requester arbiter.
// FSM state encoding, size limit and the one-hot decode helper.
package apb_arb_pkg;

    localparam int MAX_NREQ = 8;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        ISSUE  = 2'd1,
        SETUP  = 2'd2,
        ACCESS = 2'd3
    } arb_state_e;

    function automatic int onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// apb_rr_pick: combinational round-robin winner selection.
// Searches upward from ptr+1 with wrap-around; result is one-hot or zero.
module apb_rr_pick
    import apb_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx
);

    logic [NREQ-1:0]     hi;
    logic [NREQ-1:0]     lo;
    logic [NREQ-1:0]     cand;
    logic [MAX_NREQ-1:0] win_pad;

    // Candidates above the pointer outrank the wrapped-around ones.
    always_comb begin
        hi = '0;
        lo = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (eligible[i]) begin
                if (i > int'(ptr)) begin
                    hi[i] = 1'b1;
                end else begin
                    lo[i] = 1'b1;
                end
            end
        end
        cand = (|hi) ? hi : lo;
        win  = cand & (~cand + NREQ'(1));
    end

    always_comb begin
        win_pad             = '0;
        win_pad[NREQ-1:0]   = win;
        win_idx             = IW'(onehot_to_idx(win_pad));
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares one APB master among NREQ requesters.
// Round-robin grant, latched command, and local tracking of the APB phase.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_mask,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    input  logic [NREQ*DW/8-1:0] req_strb,
    output logic [NREQ-1:0]   rsp_done,
    output logic [NREQ-1:0]   rsp_err,
    output logic [NREQ-1:0]   grant,
    output logic              m_transfer,
    output logic              m_write,
    output logic [AW-1:0]     m_addr,
    output logic [DW-1:0]     m_wdata,
    output logic [DW/8-1:0]   m_strb,
    input  logic              m_ready,
    input  logic              m_slverr
);

    localparam int SW = DW / 8;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e state;
    arb_state_e state_nx;

    logic [IW-1:0]   ptr;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] win;
    logic [IW-1:0]   win_idx;
    logic            load;
    logic            clr;

    logic            sel_write;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [SW-1:0]   sel_strb;

    assign eligible = req_valid & req_mask;

    apb_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .win      (win),
        .win_idx  (win_idx)
    );

    // One-hot mux of the winning requester's command fields.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
                sel_strb  = req_strb[i*SW +: SW];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= ARB;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        clr      = 1'b0;
        unique case (state)
            ARB: begin
                if (|eligible) begin
                    load     = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                state_nx = SETUP;
            end
            SETUP: begin
                state_nx = ACCESS;
            end
            ACCESS: begin
                if (m_ready) begin
                    clr      = 1'b1;
                    state_nx = ARB;
                end
            end
            default: begin
                state_nx = ARB;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            grant   <= '0;
            ptr     <= IW'(NREQ - 1);
            m_write <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_strb  <= '0;
        end else if (load) begin
            grant   <= win;
            ptr     <= win_idx;
            m_write <= sel_write;
            m_addr  <= sel_addr;
            m_wdata <= sel_wdata;
            m_strb  <= sel_strb;
        end else if (clr) begin
            grant   <= '0;
        end
    end

    // Master leaves IDLE on the single ISSUE cycle only.
    assign m_transfer = (state == ISSUE);
    assign rsp_done   = (state == ACCESS && m_ready) ? grant : '0;
    assign rsp_err    = m_slverr ? rsp_done : '0;

endmodule
